// File: rtl/fifo_rd_prefetch_pkg.sv
`default_nettype none
// fifo_rd_prefetch_pkg: shared occupancy-state encoding and stall counter width.
// Revision: 1.0
package fifo_rd_prefetch_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;

  function automatic logic [1:0] occ_of(input state_e s);
    return 2'(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_prefetch.sv
`default_nettype none
// fifo_rd_prefetch: one-cycle-latency FIFO read port to first-word-fall-through valid/ready.
// Optional FIFO_PREFETCH_STALL_CNT_EN adds a saturating STALL_CNT output. Revision: 1.0
module fifo_rd_prefetch
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int C_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [C_WIDTH-1:0] FIFO_DATA,
  input  logic               FIFO_EMPTY,
  output logic               FIFO_RD_EN,
  output logic [C_WIDTH-1:0] DATA,
  output logic               VALID,
  input  logic               READY
`ifdef FIFO_PREFETCH_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] STALL_CNT
`endif
);

  state_e               state_q, state_d;
  logic                 infl_q;
  logic [C_WIDTH-1:0]   entry0_q, entry0_d;
  logic [C_WIDTH-1:0]   entry1_q, entry1_d;

  logic                 pop;
  logic [1:0]           occ;
  logic [1:0]           occ_after_pop;
  logic [1:0]           occ_next;
  logic [2:0]           level;

  assign VALID = (state_q != S_EMPTY);
  assign DATA  = entry0_q;

  always_comb begin
    pop           = VALID && READY;
    occ           = occ_of(state_q);
    occ_after_pop = occ - {1'b0, pop};
    level         = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    // Gating with RST_N keeps the read request low for the whole reset pulse.
    FIFO_RD_EN    = RST_N && !FIFO_EMPTY && (level < 3'd2);

    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;

    if (pop && (state_q == S_TWO)) begin
      entry0_d = entry1_q;
    end
    if (infl_q) begin
      if (occ_after_pop == 2'd0) begin
        entry0_d = FIFO_DATA;
      end else begin
        entry1_d = FIFO_DATA;
      end
    end

    occ_next = occ_after_pop + {1'b0, infl_q};
    case (occ_next)
      2'd0:    state_d = S_EMPTY;
      2'd1:    state_d = S_ONE;
      default: state_d = S_TWO;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_EMPTY;
      infl_q   <= 1'b0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      infl_q   <= FIFO_RD_EN;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert (!(infl_q && (occ_after_pop == 2'd2)));
    end
  end
`endif

`ifdef FIFO_PREFETCH_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
    end else if (VALID && !READY && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign STALL_CNT = stall_q;
`endif

endmodule
`default_nettype wire
